// File: rtl/axi_mem_read_responder.sv
// axi_mem_read_responder: AXI4 read subordinate serving INCR/WRAP/FIXED bursts
// from a word-addressed on-chip memory with a side preload port.
module axi_mem_read_responder #(
    parameter int ID_WIDTH = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ID_WIDTH-1:0]           s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [ID_WIDTH-1:0]           s_axi_rid,
    output logic [DATA_WIDTH-1:0]         s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic                          ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0]  ld_addr,
    input  logic [DATA_WIDTH-1:0]         ld_data
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS) << 3;

    typedef enum logic {IDLE, BEAT} state_t;
    state_t state, state_n;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [ADDR_WIDTH-1:0] addr_q, step, wrap_size, next_addr, beat_addr, off;
    logic [7:0] len_q, cnt_q;
    logic [2:0] size_q;
    logic [1:0] burst_q, resp_n;
    logic slv_q, slv_ar, slv, accept, advance;
    logic [AW-1:0] idx;
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        accept = s_axi_arready && s_axi_arvalid;
        advance = s_axi_rvalid && s_axi_rready;
        step = ADDR_WIDTH'(1) << size_q;
        wrap_size = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
        next_addr = burst_q == 2'b00 ? addr_q :
                    burst_q == 2'b10 ? (addr_q & ~(wrap_size - ADDR_WIDTH'(1))) |
                                       ((addr_q + step) & (wrap_size - ADDR_WIDTH'(1))) :
                    addr_q + step;
        slv_ar = s_axi_arburst == 2'b11 || s_axi_arsize > 3'd3 ||
                 (s_axi_arburst == 2'b10 && !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                 (s_axi_arburst != 2'b10 && s_axi_arlen > 8'd15);
        // The word for the beat about to be registered: start address on accept, else the successor
        beat_addr = accept ? s_axi_araddr : next_addr;
        slv = accept ? slv_ar : slv_q;
        off = beat_addr - BASE_ADDR;
        idx = off[AW+2:3];
        word = (ld_en && ld_addr == idx) ? ld_data : mem[idx];
        resp_n = slv ? 2'b10 : off >= MEM_BYTES ? 2'b11 : 2'b00;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (accept ? BEAT : IDLE) : (advance && s_axi_rlast ? IDLE : BEAT);
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;

    always_ff @(posedge clk)
        if (ld_en) mem[ld_addr] <= ld_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rlast <= 1'b0;
            s_axi_rresp <= 2'b00;
            s_axi_rid <= '0;
            s_axi_rdata <= '0;
        end else begin
            s_axi_arready <= state_n == IDLE;
            if (accept) begin
                s_axi_rid <= s_axi_arid;
                addr_q <= s_axi_araddr;
                len_q <= s_axi_arlen;
                size_q <= s_axi_arsize;
                burst_q <= s_axi_arburst;
                slv_q <= slv_ar;
                cnt_q <= 8'd0;
                s_axi_rvalid <= 1'b1;
                s_axi_rlast <= s_axi_arlen == 8'd0;
                s_axi_rresp <= resp_n;
                s_axi_rdata <= resp_n != 2'b00 ? '0 : word;
            end else if (advance) begin
                if (s_axi_rlast) begin
                    s_axi_rvalid <= 1'b0;
                    s_axi_rlast <= 1'b0;
                end else begin
                    addr_q <= next_addr;
                    cnt_q <= cnt_q + 8'd1;
                    s_axi_rlast <= cnt_q + 8'd1 == len_q;
                    s_axi_rresp <= resp_n;
                    s_axi_rdata <= resp_n != 2'b00 ? '0 : word;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_read_responder.sv
// tb_axi_mem_read_responder: scoreboarded random and directed bursts against
// an address-list reference model of the read responder.
module tb_axi_mem_read_responder;
    localparam int IDW = 13;
    localparam int NW = 4096;
    localparam logic [63:0] MEM_BYTES = 64'(NW) * 64'd8;

    logic clk = 1'b0, reset = 1'b1;
    logic [IDW-1:0] arid = '0;
    logic [63:0] araddr = '0;
    logic [7:0] arlen = '0;
    logic [2:0] arsize = '0;
    logic [1:0] arburst = '0;
    logic arvalid = 1'b0, arready;
    logic [IDW-1:0] rid;
    logic [63:0] rdata;
    logic [1:0] rresp;
    logic rlast, rvalid, rready;
    logic ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [63:0] ld_data = '0;

    int rr_mode = 0;
    logic rr_manual = 1'b1, rnd = 1'b1;
    assign rready = rr_mode == 2 ? rr_manual : rr_mode == 1 ? rnd : 1'b1;

    always #5 clk = ~clk;

    axi_mem_read_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(64), .DATA_WIDTH(64),
                             .MEM_WORDS(NW), .BASE_ADDR(64'h0)) dut (
        .clk(clk), .reset(reset),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [63:0] data;
        logic [1:0] resp;
        logic last;
    } beat_t;
    beat_t exp_q[$];
    beat_t b;
    logic [63:0] mm [NW];
    int total = 0, passed = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: list every beat address from the burst rules, then look each up
    function automatic void model(input logic [IDW-1:0] id, input logic [63:0] addr,
                                  input logic [7:0] len, input logic [2:0] size,
                                  input logic [1:0] burst);
        logic [63:0] step, wsize, low, a;
        bit slv;
        beat_t e;
        step = 64'd1 << size;
        wsize = (64'(len) + 64'd1) << size;
        low = addr - addr % wsize;
        slv = burst == 2'd3 || size > 3'd3 || (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              (burst != 2'd2 && len > 8'd15);
        for (int i = 0; i <= int'(len); i++) begin
            a = burst == 2'd0 ? addr : burst == 2'd1 ? addr + 64'(i) * step :
                low + (addr + 64'(i) * step - low) % wsize;
            e.id = id;
            e.resp = slv ? 2'b10 : a >= MEM_BYTES ? 2'b11 : 2'b00;
            e.data = e.resp != 2'b00 ? 64'h0 : mm[a[14:3]];
            e.last = i == int'(len);
            exp_q.push_back(e);
        end
    endfunction

    initial forever begin
        @(posedge clk); #1;
        rnd = 1'($urandom_range(0, 1));
    end

    logic stall = 1'b0, h_last = 1'b0;
    logic [63:0] h_data = '0;
    logic [1:0] h_resp = '0;
    logic [IDW-1:0] h_id = '0;

    always @(negedge clk) begin
        if (reset || !mon_en) stall <= 1'b0;
        else begin
            if (stall) begin
                check("hold rvalid", 64'(rvalid), 64'd1);
                check("hold rdata", rdata, h_data);
                check("hold rresp", 64'(rresp), 64'(h_resp));
                check("hold rlast", 64'(rlast), 64'(h_last));
                check("hold rid", 64'(rid), 64'(h_id));
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL extra beat: got rdata %h with no beat expected", rdata);
                end else begin
                    b = exp_q.pop_front();
                    check("rid", 64'(rid), 64'(b.id));
                    check("rdata", rdata, b.data);
                    check("rresp", 64'(rresp), 64'(b.resp));
                    check("rlast", 64'(rlast), 64'(b.last));
                end
            end
            stall <= rvalid && !rready;
            h_data <= rdata;
            h_resp <= rresp;
            h_last <= rlast;
            h_id <= rid;
        end
    end

    task automatic load(input int a, input logic [63:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1;
        ld_addr = 12'(a);
        ld_data = d;
        mm[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n;
        model(id, addr, len, size, burst);
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) begin
            total++;
            $display("FAIL ar handshake: arready still 0 after %0d cycles, required 1", n);
            arvalid = 1'b0;
            exp_q.delete();
            return;
        end
        check("idle rvalid", 64'(rvalid), 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("latency rvalid", 64'(rvalid), 64'd1);
        check("busy arready", 64'(arready), 64'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL burst timeout: %0d beats outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_rvalid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 100);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0] w, ofs;
        logic [2:0] sz;
        logic [1:0] bu;
        logic [7:0] ln;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset arready", 64'(arready), 64'd0);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset rlast", 64'(rlast), 64'd0);
        check("reset rresp", 64'(rresp), 64'd0);
        check("reset rid", 64'(rid), 64'd0);
        check("reset rdata", rdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) load(i, i < 16 ? 64'h1000 + 64'(i) : {$urandom, $urandom});
        for (int i = NW - 16; i < NW; i++) load(i, {$urandom, $urandom});
        mon_en = 1'b1;

        issue(13'd5, 64'h10, 8'd3, 3'd3, 2'b01);
        issue(13'd9, 64'h28, 8'd7, 3'd3, 2'b10);

        rr_mode = 2;
        rr_manual = 1'b1;
        fork
            issue(13'd1, 64'h0, 8'd3, 3'd3, 2'b01);
            begin
                wait_rvalid();
                @(posedge clk); #1;
                rr_manual = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("bp rvalid", 64'(rvalid), 64'd1);
                    check("bp rdata", rdata, 64'h1001);
                end
                @(posedge clk); #1;
                rr_manual = 1'b1;
            end
        join
        rr_mode = 0;

        issue(13'd2, MEM_BYTES, 8'd1, 3'd3, 2'b01);
        issue(13'd3, 64'h0, 8'd2, 3'd3, 2'b10);
        issue(13'd4, 64'h8, 8'd0, 3'd3, 2'b11);

        mon_en = 1'b0;
        @(posedge clk); #1;
        arid = 13'd7; araddr = 64'h0; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid-burst reset rvalid", 64'(rvalid), 64'd0);
        @(negedge clk);
        check("post-reset arready", 64'(arready), 64'd1);
        check("post-reset rvalid", 64'(rvalid), 64'd0);
        mon_en = 1'b1;
        issue(13'd8, 64'h0, 8'd0, 3'd3, 2'b01);

        mm[2] = 64'hDEAD;
        fork
            issue(13'd6, 64'h0, 8'd3, 3'd3, 2'b01);
            begin
                wait_rvalid();
                ld_en = 1'b1;
                ld_addr = 12'd2;
                ld_data = 64'hDEAD;
                @(posedge clk); #1;
                ld_en = 1'b0;
            end
        join

        rr_mode = 1;
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(0, 9));
            bu = n < 4 ? 2'b01 : n < 6 ? 2'b10 : n < 8 ? 2'b00 : 2'b11;
            sz = $urandom_range(0, 99) < 85 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            if (bu == 2'b10 && $urandom_range(0, 4) != 0) ln = (8'd2 << $urandom_range(0, 3)) - 8'd1;
            else ln = $urandom_range(0, 99) < 85 ? 8'($urandom_range(0, 15)) : 8'($urandom_range(16, 40));
            n = int'($urandom_range(0, 9));
            w = n < 6 ? 64'($urandom_range(0, 47)) : n < 9 ? 64'($urandom_range(NW - 16, NW - 1)) :
                64'h1000 + 64'($urandom_range(0, 4095));
            ofs = sz > 3'd3 ? 64'd0 : 64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(13'($urandom), w * 64'd8 + ofs, ln, sz, bu);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
